// File: rtl/pcie_tx_pkt_arbiter.sv
// Packet-atomic 2:1 round-robin arbiter for the PCIe SS AXI-S TX stream.
// Optional per-port packet counters are built when PCIE_TX_ARB_CNT_EN is defined.
module pcie_tx_pkt_arbiter #(
    parameter int DATA_W    = 512,
    parameter int USER_W    = 10,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int MAX_BEATS = 64
) (
    input  logic              fim_clk,
    input  logic              fim_rst_n,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic [USER_W-1:0] s0_tuser,
    input  logic              s0_tlast,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic [USER_W-1:0] s1_tuser,
    input  logic              s1_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic [USER_W-1:0] m_tuser,
    output logic              m_tlast,
    output logic [1:0]        grant,
    output logic              oversize_err
`ifdef PCIE_TX_ARB_CNT_EN
    ,
    output logic [31:0]       pkt_cnt0,
    output logic [31:0]       pkt_cnt1
`endif
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] BEAT_SAT  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic             beat_acc;

    assign beat_acc = m_tvalid & m_tready;

    always_ff @(posedge fim_clk) begin
        if (!fim_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshakes are gated by reset so nothing is accepted while the FSM is being cleared.
    always_comb begin
        state_nxt = state;
        grant     = 2'b00;
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tuser   = '0;
        m_tlast   = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state)
            IDLE: begin
                if (s0_tvalid && (!s1_tvalid || !rr_ptr)) begin
                    state_nxt = OWN0;
                end else if (s1_tvalid) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                grant     = 2'b01;
                m_tvalid  = s0_tvalid & fim_rst_n;
                m_tdata   = s0_tdata;
                m_tkeep   = s0_tkeep;
                m_tuser   = s0_tuser;
                m_tlast   = s0_tlast;
                s0_tready = m_tready & fim_rst_n;
                if (s0_tvalid && m_tready && s0_tlast) begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                grant     = 2'b10;
                m_tvalid  = s1_tvalid & fim_rst_n;
                m_tdata   = s1_tdata;
                m_tkeep   = s1_tkeep;
                m_tuser   = s1_tuser;
                m_tlast   = s1_tlast;
                s1_tready = m_tready & fim_rst_n;
                if (s1_tvalid && m_tready && s1_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Round-robin pointer hands priority to the other port after each completed packet.
    always_ff @(posedge fim_clk) begin
        if (!fim_rst_n) begin
            rr_ptr       <= 1'b0;
            beat_cnt     <= '0;
            oversize_err <= 1'b0;
        end else if (beat_acc) begin
            if (m_tlast) begin
                beat_cnt <= '0;
                rr_ptr   <= (state == OWN0);
            end else begin
                if (beat_cnt < BEAT_SAT) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
                if (beat_cnt >= BEAT_LAST) begin
                    oversize_err <= 1'b1;
                end
            end
        end
    end

`ifdef PCIE_TX_ARB_CNT_EN
    always_ff @(posedge fim_clk) begin
        if (!fim_rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (beat_acc && m_tlast) begin
            if (state == OWN0) begin
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
            if (state == OWN1) begin
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
            end
        end
    end
`else
    // Packet counters are not built in this configuration.
`endif

endmodule
